// File: rtl/board_pkg.sv
// Board-wide clock constants, button timing defaults and the auto-repeat state type.
package board_pkg;

  localparam int CLK_HZ           = 100_000_000;
  localparam int CYCLES_PER_MS    = CLK_HZ / 1000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int REPEAT_DELAY_MS  = 500;
  localparam int REPEAT_PERIOD_MS = 100;

  localparam int DEBOUNCE_CYCLES_DEF = DEBOUNCE_MS * CYCLES_PER_MS;
  localparam int REPEAT_DELAY_DEF    = REPEAT_DELAY_MS * CYCLES_PER_MS;
  localparam int REPEAT_PERIOD_DEF   = REPEAT_PERIOD_MS * CYCLES_PER_MS;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the conditioned control outputs.
interface button_conditioner_if #(
  parameter int N_BTNS = 4
);

  logic [N_BTNS-1:0] btn_in;
  logic [N_BTNS-1:0] repeat_en_in;
  logic [N_BTNS-1:0] level_out;
  logic [N_BTNS-1:0] press_out;
  logic [N_BTNS-1:0] release_out;
  logic [N_BTNS-1:0] repeat_out;

  modport master (
    output btn_in,
    output repeat_en_in,
    input  level_out,
    input  press_out,
    input  release_out,
    input  repeat_out
  );

  modport slave (
    input  btn_in,
    input  repeat_en_in,
    output level_out,
    output press_out,
    output release_out,
    output repeat_out
  );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce counter, press/release pulses
// and the hold-to-repeat state machine.
module debounce_channel
  import board_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_repeat;
  rpt_state_e             r_state;
  logic [RP_W-1:0]        r_rpt_cnt;

  logic                   w_differ;
  logic                   w_accept;
  logic                   w_press;
  logic                   w_release;
  rpt_state_e             w_state_nxt;
  logic [RP_W-1:0]        w_rpt_cnt_nxt;
  logic                   w_rpt_pulse;

  assign w_differ  = r_sync[SYNC_STAGES-1] ^ r_level;
  assign w_accept  = w_differ && (r_db_cnt == DB_LAST);
  assign w_press   = w_accept && !r_level;
  assign w_release = w_accept && r_level;

  // Metastability chain; only the last stage is trusted downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  // Debounce counter, accepted level and edge pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      if (!w_differ || w_accept) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      r_level   <= r_level ^ w_accept;
      r_press   <= w_press;
      r_release <= w_release;
      r_repeat  <= w_press | w_rpt_pulse;
    end
  end

  // Repeat state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RPT_IDLE;
      r_rpt_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rpt_cnt <= w_rpt_cnt_nxt;
    end
  end

  // A release decided this edge aborts repeating so no pulse lands in the release cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_rpt_pulse   = 1'b0;
    case (r_state)
      RPT_IDLE: begin
        w_rpt_cnt_nxt = '0;
        if (i_repeat_en && (w_press || (r_level && !w_release))) begin
          w_state_nxt = RPT_DELAY;
        end else begin
          w_state_nxt = RPT_IDLE;
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        if (!r_level || !i_repeat_en || w_release) begin
          w_state_nxt   = RPT_IDLE;
          w_rpt_cnt_nxt = '0;
        end else if (r_rpt_cnt == ((r_state == RPT_DELAY) ? RD_LAST : RP_LAST)) begin
          w_state_nxt   = RPT_REPEAT;
          w_rpt_cnt_nxt = '0;
          w_rpt_pulse   = 1'b1;
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = RPT_IDLE;
        w_rpt_cnt_nxt = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel pushbutton front end: N_BTNS independent debounce channels
// behind the board button pins.
module button_conditioner
  import board_pkg::*;
#(
  parameter int N_BTNS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input logic                 clk_in,
  input logic                 rst_in,
  button_conditioner_if.slave bus
);

  logic [N_BTNS-1:0] w_level;
  logic [N_BTNS-1:0] w_press;
  logic [N_BTNS-1:0] w_release;
  logic [N_BTNS-1:0] w_repeat;

  for (genvar g = 0; g < N_BTNS; g++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .i_clk      (clk_in),
      .i_rst      (rst_in),
      .i_btn      (bus.btn_in[g]),
      .i_repeat_en(bus.repeat_en_in[g]),
      .o_level    (w_level[g]),
      .o_press    (w_press[g]),
      .o_release  (w_release[g]),
      .o_repeat   (w_repeat[g])
    );
  end

  assign bus.level_out   = w_level;
  assign bus.press_out   = w_press;
  assign bus.release_out = w_release;
  assign bus.repeat_out  = w_repeat;

endmodule
